// File: rtl/udp_frame_header_builder.sv
// rtl/udp_frame_header_builder.sv - writes the 42-byte Ethernet/IPv4/UDP header to DPRAM port A and fills in the IP checksum
module udp_frame_header_builder #(
  parameter logic [9:0] BASE_ADDR = 10'd0,
  parameter logic [7:0] TTL       = 8'h40
) (
  input  logic        iDm9000aClk,
  input  logic        iRst,
  input  logic        iBuildStart,
  input  logic [47:0] iDstMac,
  input  logic [47:0] iSrcMac,
  input  logic [31:0] iSrcIp,
  input  logic [31:0] iDstIp,
  input  logic [15:0] iSrcPort,
  input  logic [15:0] iDstPort,
  input  logic [15:0] iPayloadLen,
  output logic        wren_a,
  output logic [9:0]  address_a,
  output logic [7:0]  data_a,
  output logic        oChkRunStart,
  output logic [15:0] oChkLen,
  output logic [9:0]  oChkStartAddr,
  input  logic        iChkRunEnd,
  input  logic [15:0] iChecksum,
  output logic [15:0] oFrameLen,
  output logic        oBuildBusy,
  output logic        oBuildDone,
  output logic        oLenErr,
  output logic        oChkErr
);

  localparam logic [15:0] MAX_PAYLOAD = 16'd982;
  localparam logic [5:0]  LAST_IDX    = 6'd41;
  localparam logic [7:0]  TMO_LAST    = 8'd254;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_HDR, S_CHK_WAIT, S_WR_CS_H, S_WR_CS_L, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [5:0]  idx, idx_n, idx_inc;
  logic [7:0]  tmo, tmo_n;
  logic [7:0]  cs_lo, cs_lo_n;
  logic [15:0] id, id_n;
  logic        wren_n;
  logic [9:0]  addr_n;
  logic [7:0]  data_n;
  logic [15:0] frame_len_n;
  logic        len_err_n, chk_err_n;
  logic        latch;

  logic [47:0] dst_mac, src_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, pay_len;
  logic [15:0] ip_total_len, udp_len;
  logic [335:0] hdr;
  logic [8:0]  sel_bit;

  assign ip_total_len = pay_len + 16'd28;
  assign udp_len      = pay_len + 16'd8;

  // Byte 0 sits in the top bits so byte k is hdr[(41-k)*8 +: 8].
  assign hdr = {dst_mac, src_mac, 16'h0800,
                8'h45, 8'h00, ip_total_len, id, 16'h4000, TTL, 8'h11, 16'h0000,
                src_ip, dst_ip,
                src_port, dst_port, udp_len, 16'h0000};

  assign idx_inc = idx + 6'd1;
  assign sel_bit = {LAST_IDX - idx_inc, 3'b000};

  assign oChkLen       = 16'd20;
  assign oChkStartAddr = BASE_ADDR + 10'd14;
  assign oChkRunStart  = (state == S_CHK_WAIT);
  assign oBuildBusy    = (state != S_IDLE);
  assign oBuildDone    = (state == S_DONE);

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    tmo_n       = tmo;
    cs_lo_n     = cs_lo;
    id_n        = id;
    wren_n      = 1'b0;
    addr_n      = address_a;
    data_n      = data_a;
    frame_len_n = oFrameLen;
    len_err_n   = oLenErr;
    chk_err_n   = oChkErr;
    latch       = 1'b0;

    case (state)
      S_IDLE: begin
        if (iBuildStart) begin
          latch       = 1'b1;
          chk_err_n   = 1'b0;
          len_err_n   = (iPayloadLen > MAX_PAYLOAD);
          frame_len_n = (iPayloadLen < 16'd18) ? 16'd60 : iPayloadLen + 16'd42;
          if (iPayloadLen > MAX_PAYLOAD) begin
            state_n = S_DONE;
          end else begin
            // Byte 0 comes straight from the port so it lands the cycle after start.
            state_n = S_WR_HDR;
            idx_n   = 6'd0;
            wren_n  = 1'b1;
            addr_n  = BASE_ADDR;
            data_n  = iDstMac[47:40];
          end
        end
      end
      S_WR_HDR: begin
        if (idx == LAST_IDX) begin
          state_n = S_CHK_WAIT;
          tmo_n   = 8'd0;
        end else begin
          idx_n  = idx_inc;
          wren_n = 1'b1;
          addr_n = BASE_ADDR + {4'd0, idx_inc};
          data_n = hdr[sel_bit +: 8];
        end
      end
      S_CHK_WAIT: begin
        if (iChkRunEnd) begin
          state_n = S_WR_CS_H;
          wren_n  = 1'b1;
          addr_n  = BASE_ADDR + 10'd24;
          data_n  = ~iChecksum[15:8];
          cs_lo_n = ~iChecksum[7:0];
        end else if (tmo == TMO_LAST) begin
          state_n   = S_DONE;
          chk_err_n = 1'b1;
        end else begin
          tmo_n = tmo + 8'd1;
        end
      end
      S_WR_CS_H: begin
        state_n = S_WR_CS_L;
        wren_n  = 1'b1;
        addr_n  = BASE_ADDR + 10'd25;
        data_n  = cs_lo;
      end
      S_WR_CS_L: begin
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
        if (!oLenErr && !oChkErr) id_n = id + 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      state     <= S_IDLE;
      idx       <= 6'd0;
      tmo       <= 8'd0;
      cs_lo     <= 8'd0;
      id        <= 16'd0;
      wren_a    <= 1'b0;
      address_a <= 10'd0;
      data_a    <= 8'd0;
      oFrameLen <= 16'd0;
      oLenErr   <= 1'b0;
      oChkErr   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tmo       <= tmo_n;
      cs_lo     <= cs_lo_n;
      id        <= id_n;
      wren_a    <= wren_n;
      address_a <= addr_n;
      data_a    <= data_n;
      oFrameLen <= frame_len_n;
      oLenErr   <= len_err_n;
      oChkErr   <= chk_err_n;
    end
  end

  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      dst_mac  <= 48'd0;
      src_mac  <= 48'd0;
      src_ip   <= 32'd0;
      dst_ip   <= 32'd0;
      src_port <= 16'd0;
      dst_port <= 16'd0;
      pay_len  <= 16'd0;
    end else if (latch) begin
      dst_mac  <= iDstMac;
      src_mac  <= iSrcMac;
      src_ip   <= iSrcIp;
      dst_ip   <= iDstIp;
      src_port <= iSrcPort;
      dst_port <= iDstPort;
      pay_len  <= iPayloadLen;
    end
  end

endmodule

// File: tb/tb_udp_frame_header_builder.sv
// tb/tb_udp_frame_header_builder.sv - scoreboard bench for udp_frame_header_builder
module tb_udp_frame_header_builder;

  logic        clk = 1'b0;
  logic        iRst, iBuildStart;
  logic [47:0] iDstMac, iSrcMac;
  logic [31:0] iSrcIp, iDstIp;
  logic [15:0] iSrcPort, iDstPort, iPayloadLen;
  logic        wren_a;
  logic [9:0]  address_a;
  logic [7:0]  data_a;
  logic        oChkRunStart;
  logic [15:0] oChkLen;
  logic [9:0]  oChkStartAddr;
  logic        iChkRunEnd;
  logic [15:0] iChecksum;
  logic [15:0] oFrameLen;
  logic        oBuildBusy, oBuildDone, oLenErr, oChkErr;

  always #5 clk = ~clk;

  udp_frame_header_builder #(.BASE_ADDR(10'd0), .TTL(8'h40)) dut (
    .iDm9000aClk(clk), .iRst(iRst), .iBuildStart(iBuildStart),
    .iDstMac(iDstMac), .iSrcMac(iSrcMac), .iSrcIp(iSrcIp), .iDstIp(iDstIp),
    .iSrcPort(iSrcPort), .iDstPort(iDstPort), .iPayloadLen(iPayloadLen),
    .wren_a(wren_a), .address_a(address_a), .data_a(data_a),
    .oChkRunStart(oChkRunStart), .oChkLen(oChkLen), .oChkStartAddr(oChkStartAddr),
    .iChkRunEnd(iChkRunEnd), .iChecksum(iChecksum), .oFrameLen(oFrameLen),
    .oBuildBusy(oBuildBusy), .oBuildDone(oBuildDone), .oLenErr(oLenErr), .oChkErr(oChkErr)
  );

  typedef struct packed {
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
    logic [15:0] id;
  } frame_t;
  typedef struct { logic [9:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { logic len_err; logic chk_err; logic [15:0] flen; int cyc; } done_t;

  wr_t         exp_wr[$];
  done_t       exp_done[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  bit          eng_en = 1'b1;
  logic [15:0] eng_cs = 16'h0000;
  int          eng_cnt = 0;
  logic [7:0]  mem [0:1023];
  logic [7:0]  ip_ref [0:19];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte(input frame_t f, input int k);
    logic [15:0] tl, ul;
    tl = f.len + 16'd28;
    ul = f.len + 16'd8;
    if (k <= 5) return f.dmac[8*(5-k) +: 8];
    if (k <= 11) return f.smac[8*(11-k) +: 8];
    if (k >= 26 && k <= 29) return f.sip[8*(29-k) +: 8];
    if (k >= 30 && k <= 33) return f.dip[8*(33-k) +: 8];
    case (k)
      12: return 8'h08;
      14: return 8'h45;
      16: return tl[15:8];
      17: return tl[7:0];
      18: return f.id[15:8];
      19: return f.id[7:0];
      20: return 8'h40;
      22: return 8'h40;
      23: return 8'h11;
      34: return f.sp[15:8];
      35: return f.sp[7:0];
      36: return f.dp[15:8];
      37: return f.dp[7:0];
      38: return ul[15:8];
      39: return ul[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Checksum engine stand-in: answers five cycles into a run, drops when the run ends.
  initial forever begin
    @(negedge clk);
    if (oChkRunStart && eng_en) begin
      eng_cnt++;
      if (eng_cnt >= 5) begin
        iChkRunEnd = 1'b1;
        iChecksum  = eng_cs;
      end
    end else begin
      eng_cnt    = 0;
      iChkRunEnd = 1'b0;
      iChecksum  = 16'hDEAD;
    end
  end

  initial forever begin
    wr_t   w;
    done_t d;
    @(negedge clk);
    if (wren_a) begin
      mem[address_a] = data_a;
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", {14'd0, address_a, data_a}, 32'hFFFF_FFFF);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", {22'd0, address_a}, {22'd0, w.addr});
        chk("wr_data", {24'd0, data_a}, {24'd0, w.data});
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (oBuildDone) begin
      done_cnt++;
      if (exp_done.size() == 0) begin
        chk("unexpected_done", cyc, 32'hFFFF_FFFF);
      end else begin
        d = exp_done.pop_front();
        chk("done_len_err", {31'd0, oLenErr}, {31'd0, d.len_err});
        chk("done_chk_err", {31'd0, oChkErr}, {31'd0, d.chk_err});
        chk("done_frame_len", {16'd0, oFrameLen}, {16'd0, d.flen});
        chk("done_cycle", cyc, d.cyc);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget);
    int i = 0;
    while (done_cnt < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", {31'd0, done_cnt >= target}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wren"}, {31'd0, wren_a}, 32'd0);
    chk({tag, "_addr"}, {22'd0, address_a}, 32'd0);
    chk({tag, "_data"}, {24'd0, data_a}, 32'd0);
    chk({tag, "_run"}, {31'd0, oChkRunStart}, 32'd0);
    chk({tag, "_flen"}, {16'd0, oFrameLen}, 32'd0);
    chk({tag, "_busy"}, {31'd0, oBuildBusy}, 32'd0);
    chk({tag, "_done"}, {31'd0, oBuildDone}, 32'd0);
    chk({tag, "_lenerr"}, {31'd0, oLenErr}, 32'd0);
    chk({tag, "_chkerr"}, {31'd0, oChkErr}, 32'd0);
  endtask

  task automatic start_build(input frame_t f, input int n_hdr, input bit do_cs,
                             input bit do_done, input bit le, input bit ce,
                             input int done_off, output int n);
    logic [15:0] flen;
    wr_t   w;
    done_t d;
    flen = (f.len < 16'd18) ? 16'd60 : f.len + 16'd42;
    @(negedge clk);
    n = cyc + 1;
    for (int k = 0; k < n_hdr; k++) begin
      w.addr = 10'(k); w.data = exp_byte(f, k); w.cyc = n + k;
      exp_wr.push_back(w);
    end
    if (do_cs) begin
      w.addr = 10'd24; w.data = ~eng_cs[15:8]; w.cyc = n + 47;
      exp_wr.push_back(w);
      w.addr = 10'd25; w.data = ~eng_cs[7:0]; w.cyc = n + 48;
      exp_wr.push_back(w);
    end
    if (do_done) begin
      d.len_err = le; d.chk_err = ce; d.flen = flen; d.cyc = n + done_off;
      exp_done.push_back(d);
    end
    iDstMac = f.dmac; iSrcMac = f.smac; iSrcIp = f.sip; iDstIp = f.dip;
    iSrcPort = f.sp; iDstPort = f.dp; iPayloadLen = f.len;
    iBuildStart = 1'b1;
    @(negedge clk);
    iBuildStart = 1'b0;
    iDstMac = ~f.dmac; iSrcMac = ~f.smac; iSrcIp = ~f.sip; iDstIp = ~f.dip;
    iSrcPort = ~f.sp; iDstPort = ~f.dp; iPayloadLen = 16'd5;
    chk("frame_len_after_start", {16'd0, oFrameLen}, {16'd0, flen});
    chk("busy_after_start", {31'd0, oBuildBusy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    frame_t f;
    int n, d0;
    ip_ref = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    iRst = 1'b1; iBuildStart = 1'b0;
    iDstMac = '0; iSrcMac = '0; iSrcIp = '0; iDstIp = '0;
    iSrcPort = '0; iDstPort = '0; iPayloadLen = '0;
    iChkRunEnd = 1'b0; iChecksum = 16'h0000;

    repeat (3) @(negedge clk);
    check_reset("in_reset");
    iRst = 1'b0;
    @(negedge clk);
    check_reset("idle");
    chk("chk_len", {16'd0, oChkLen}, 32'd20);
    chk("chk_start_addr", {22'd0, oChkStartAddr}, 32'd14);

    // Reference frame from the worked example.
    f.dmac = 48'h0011_2233_4455; f.smac = 48'h6677_8899_AABB;
    f.sip = 32'hC0A8_0001; f.dip = 32'hC0A8_00C7;
    f.sp = 16'h1234; f.dp = 16'h5678; f.len = 16'd87; f.id = 16'd0;
    eng_en = 1'b1; eng_cs = 16'h479E;
    d0 = done_cnt;
    start_build(f, 42, 1'b1, 1'b1, 1'b0, 1'b0, 49, n);
    wait_done(d0 + 1, 100);
    for (int i = 0; i < 20; i++) chk("ip_hdr_byte", {24'd0, mem[14+i]}, {24'd0, ip_ref[i]});

    // Second good build with zero payload: ID 1, minimum frame.
    f.len = 16'd0; f.id = 16'd1; eng_cs = 16'h0000;
    d0 = done_cnt;
    start_build(f, 42, 1'b1, 1'b1, 1'b0, 1'b0, 49, n);
    wait_done(d0 + 1, 100);
    chk("id_hi_2nd", {24'd0, mem[18]}, 32'h00);
    chk("id_lo_2nd", {24'd0, mem[19]}, 32'h01);
    chk("tot_len_hi_0", {24'd0, mem[16]}, 32'h00);
    chk("tot_len_lo_0", {24'd0, mem[17]}, 32'h1C);
    chk("udp_len_hi_0", {24'd0, mem[38]}, 32'h00);
    chk("udp_len_lo_0", {24'd0, mem[39]}, 32'h08);
    chk("cs_written_ff", {24'd0, mem[24]}, 32'hFF);

    // Oversize payload: no writes, done the cycle after start.
    f.len = 16'd983;
    d0 = done_cnt;
    start_build(f, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, n);
    wait_done(d0 + 1, 10);
    chk("len_err_held", {31'd0, oLenErr}, 32'd1);

    // Engine never answers: timeout, checksum bytes stay zero.
    eng_en = 1'b0;
    f.len = 16'd100; f.id = 16'd2;
    d0 = done_cnt;
    start_build(f, 42, 1'b0, 1'b1, 1'b0, 1'b1, 297, n);
    wait_done(d0 + 1, 400);
    chk("timeout_cs_hi", {24'd0, mem[24]}, 32'h00);
    chk("timeout_cs_lo", {24'd0, mem[25]}, 32'h00);
    chk("chk_err_held", {31'd0, oChkErr}, 32'd1);

    // Starts while busy and in the done cycle are ignored.
    eng_en = 1'b1; eng_cs = 16'hA5C3;
    f.len = 16'd17; f.id = 16'd2;
    d0 = done_cnt;
    start_build(f, 42, 1'b1, 1'b1, 1'b0, 1'b0, 49, n);
    wait_until(n + 10);
    iBuildStart = 1'b1; @(negedge clk); iBuildStart = 1'b0;
    wait_until(n + 44);
    chk("run_high_in_wait", {31'd0, oChkRunStart}, 32'd1);
    iBuildStart = 1'b1; @(negedge clk); iBuildStart = 1'b0;
    wait_until(n + 49);
    chk("done_pulse_cycle", {31'd0, oBuildDone}, 32'd1);
    iBuildStart = 1'b1; @(negedge clk); iBuildStart = 1'b0;
    chk("start_in_done_ignored", {31'd0, oBuildBusy}, 32'd0);
    chk("id_lo_after_errs", {24'd0, mem[19]}, 32'h02);
    chk("cs_lo_written", {24'd0, mem[25]}, 32'h3C);

    // Reset while writing byte 20.
    f.len = 16'd50; f.id = 16'd3;
    start_build(f, 21, 1'b0, 1'b0, 1'b0, 1'b0, 0, n);
    wait_until(n + 20);
    iRst = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    repeat (2) begin
      @(negedge clk);
      chk("run_low_in_reset", {31'd0, oChkRunStart}, 32'd0);
    end
    iRst = 1'b0;
    @(negedge clk);

    // Maximum legal payload after reset: ID back to zero.
    f.len = 16'd982; f.id = 16'd0; eng_cs = 16'h1357;
    d0 = done_cnt;
    start_build(f, 42, 1'b1, 1'b1, 1'b0, 1'b0, 49, n);
    wait_done(d0 + 1, 100);
    chk("id_hi_after_reset", {24'd0, mem[18]}, 32'h00);
    chk("id_lo_after_reset", {24'd0, mem[19]}, 32'h00);
    chk("tot_len_hi_982", {24'd0, mem[16]}, 32'h03);
    chk("tot_len_lo_982", {24'd0, mem[17]}, 32'hF2);
    chk("udp_len_hi_982", {24'd0, mem[38]}, 32'h03);
    chk("udp_len_lo_982", {24'd0, mem[39]}, 32'hDE);

    repeat (3) @(negedge clk);
    chk("writes_left", exp_wr.size(), 32'd0);
    chk("dones_left", exp_done.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
